// File: rtl/updown_pkg.sv
// Shared types and default widths for the up/down counter link.
// Used by the stream decoder and its step classifier.
package updown_pkg;

    localparam int W_DEF         = 3;
    localparam int ERR_CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2,
        ERROR  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        STEP_UP   = 2'd0,
        STEP_DOWN = 2'd1,
        STEP_BAD  = 2'd2
    } step_t;

endpackage

// File: rtl/updown_step_classify.sv
// Combinational step classifier: (count - prev) mod 2^W is +1 (UP), -1 (DOWN) or BAD.
// No state, no latency, no backpressure.
module updown_step_classify
    import updown_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [W-1:0] i_count,
    input  logic [W-1:0] i_prev,
    output step_t        o_step
);

    logic [W-1:0] w_delta;

    // Modular subtraction makes the wrap cases (max->0, 0->max) fall out naturally.
    assign w_delta = i_count - i_prev;

    always_comb begin
        o_step = STEP_BAD;
        if (w_delta == W'(1)) begin
            o_step = STEP_UP;
        end else if (w_delta == {W{1'b1}}) begin
            o_step = STEP_DOWN;
        end
    end

endmodule

// File: rtl/updown_count_decoder.sv
// Recovers direction, reversal pulses, lock state and a saturating error count from an observed counter stream.
// All outputs registered, one cycle after the accepted sample; input is always accepted (no backpressure).
module updown_count_decoder
    import updown_pkg::*;
#(
    parameter int W         = W_DEF,
    parameter int ERR_CNT_W = ERR_CNT_W_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    input  logic [W-1:0]         count_i,
    output logic                 dir_o,
    output logic                 mode_o,
    output logic                 locked_o,
    output logic                 err_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
);

    state_t               r_state;
    logic [W-1:0]         r_prev;
    logic                 r_dir;
    logic                 r_mode;
    logic                 r_err;
    logic [ERR_CNT_W-1:0] r_err_cnt;

    step_t                w_step;
    logic                 w_step_up;
    logic                 w_err_sat;

    updown_step_classify #(
        .W (W)
    ) u_classify (
        .i_count (count_i),
        .i_prev  (r_prev),
        .o_step  (w_step)
    );

    assign w_step_up = (w_step == STEP_UP);
    assign w_err_sat = (r_err_cnt == {ERR_CNT_W{1'b1}});

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= IDLE;
            r_prev    <= '0;
            r_dir     <= 1'b1;
            r_mode    <= 1'b0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_mode <= 1'b0;
            r_err  <= 1'b0;
            if (valid_i) begin
                r_prev <= count_i;
                case (r_state)
                    IDLE: begin
                        r_state <= SYNC;
                    end
                    // Before first lock a BAD step is just noise while acquiring.
                    SYNC: begin
                        if (w_step != STEP_BAD) begin
                            r_state <= LOCKED;
                            r_dir   <= w_step_up;
                        end
                    end
                    LOCKED: begin
                        if (w_step == STEP_BAD) begin
                            r_state <= ERROR;
                            r_err   <= 1'b1;
                            if (!w_err_sat) begin
                                r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
                            end
                        end else if (w_step_up != r_dir) begin
                            r_dir  <= w_step_up;
                            r_mode <= 1'b1;
                        end
                    end
                    ERROR: begin
                        if (w_step == STEP_BAD) begin
                            r_err <= 1'b1;
                            if (!w_err_sat) begin
                                r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
                            end
                        end else begin
                            r_state <= LOCKED;
                            r_dir   <= w_step_up;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign dir_o     = r_dir;
    assign mode_o    = r_mode;
    assign err_o     = r_err;
    assign err_cnt_o = r_err_cnt;
    assign locked_o  = (r_state == LOCKED);

endmodule

// File: tb/tb_updown_count_decoder.sv
// Directed-vector bench: default-width decoder plus a 2-bit error-counter instance for saturation.
module tb_updown_count_decoder;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       valid_i = 1'b0;
    logic [2:0] count_i = 3'd0;

    logic       dir_o, mode_o, locked_o, err_o;
    logic [7:0] err_cnt_o;
    logic       s_dir_o, s_mode_o, s_locked_o, s_err_o;
    logic [1:0] s_err_cnt_o;

    int vectors = 0;
    int miscompares = 0;

    updown_count_decoder #(.W(3), .ERR_CNT_W(8)) u_dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .valid_i   (valid_i),
        .count_i   (count_i),
        .dir_o     (dir_o),
        .mode_o    (mode_o),
        .locked_o  (locked_o),
        .err_o     (err_o),
        .err_cnt_o (err_cnt_o)
    );

    updown_count_decoder #(.W(3), .ERR_CNT_W(2)) u_dut_sat (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .valid_i   (valid_i),
        .count_i   (count_i),
        .dir_o     (s_dir_o),
        .mode_o    (s_mode_o),
        .locked_o  (s_locked_o),
        .err_o     (s_err_o),
        .err_cnt_o (s_err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Drive on the falling edge, return 1 time unit after the rising edge for sampling.
    task automatic drive(input logic r, input logic v, input logic [2:0] c);
        @(negedge clk_i);
        rst_i   = r;
        valid_i = v;
        count_i = c;
        @(posedge clk_i);
        #1;
    endtask

    // Expected flags are packed {locked, dir, mode, err}.
    task automatic test_reset();
        drive(1'b1, 1'b1, 3'd3);
        vectors++;
        if ({locked_o, dir_o, mode_o, err_o} !== 4'b0100 || err_cnt_o !== 8'd0) begin
            miscompares++;
            $display("FAIL reset flags=%b cnt=%0d want flags=0100 cnt=0",
                     {locked_o, dir_o, mode_o, err_o}, err_cnt_o);
        end
        vectors++;
        if ({s_locked_o, s_dir_o, s_mode_o, s_err_o} !== 4'b0100 || s_err_cnt_o !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_sat flags=%b cnt=%0d want flags=0100 cnt=0",
                     {s_locked_o, s_dir_o, s_mode_o, s_err_o}, s_err_cnt_o);
        end
    endtask

    task automatic test_count_up();
        logic [2:0] s [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
        logic [3:0] e [4] = '{4'b0100, 4'b1100, 4'b1100, 4'b1100};
        drive(1'b1, 1'b0, 3'd0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, s[i]);
            vectors++;
            if ({locked_o, dir_o, mode_o, err_o} !== e[i] || err_cnt_o !== 8'd0) begin
                miscompares++;
                $display("FAIL count_up[%0d] flags=%b cnt=%0d want flags=%b cnt=0",
                         i, {locked_o, dir_o, mode_o, err_o}, err_cnt_o, e[i]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [2:0] s [7] = '{3'd6, 3'd7, 3'd0, 3'd1, 3'd0, 3'd7, 3'd6};
        logic [3:0] e [7] = '{4'b0100, 4'b1100, 4'b1100, 4'b1100,
                              4'b1010, 4'b1000, 4'b1000};
        drive(1'b1, 1'b0, 3'd0);
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 1'b1, s[i]);
            vectors++;
            if ({locked_o, dir_o, mode_o, err_o} !== e[i] || err_cnt_o !== 8'd0) begin
                miscompares++;
                $display("FAIL wrap[%0d] flags=%b cnt=%0d want flags=%b cnt=0",
                         i, {locked_o, dir_o, mode_o, err_o}, err_cnt_o, e[i]);
            end
        end
    endtask

    task automatic test_reversal();
        logic [2:0] s [5] = '{3'd0, 3'd1, 3'd2, 3'd1, 3'd0};
        logic [3:0] e [5] = '{4'b0100, 4'b1100, 4'b1100, 4'b1010, 4'b1000};
        drive(1'b1, 1'b0, 3'd0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, s[i]);
            vectors++;
            if ({locked_o, dir_o, mode_o, err_o} !== e[i] || err_cnt_o !== 8'd0) begin
                miscompares++;
                $display("FAIL reversal[%0d] flags=%b cnt=%0d want flags=%b cnt=0",
                         i, {locked_o, dir_o, mode_o, err_o}, err_cnt_o, e[i]);
            end
        end
    endtask

    task automatic test_error_recover();
        logic [2:0] s [4] = '{3'd2, 3'd3, 3'd5, 3'd6};
        logic [3:0] e [4] = '{4'b0100, 4'b1100, 4'b0101, 4'b1100};
        int         c [4] = '{0, 0, 1, 1};
        drive(1'b1, 1'b0, 3'd0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, s[i]);
            vectors++;
            if ({locked_o, dir_o, mode_o, err_o} !== e[i] || err_cnt_o !== 8'(c[i])) begin
                miscompares++;
                $display("FAIL error_recover[%0d] flags=%b cnt=%0d want flags=%b cnt=%0d",
                         i, {locked_o, dir_o, mode_o, err_o}, err_cnt_o, e[i], c[i]);
            end
        end
    endtask

    task automatic test_sync_bad();
        logic [2:0] s [4] = '{3'd3, 3'd3, 3'd5, 3'd4};
        logic [3:0] e [4] = '{4'b0100, 4'b0100, 4'b0100, 4'b1000};
        drive(1'b1, 1'b0, 3'd0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, s[i]);
            vectors++;
            if ({locked_o, dir_o, mode_o, err_o} !== e[i] || err_cnt_o !== 8'd0) begin
                miscompares++;
                $display("FAIL sync_bad[%0d] flags=%b cnt=%0d want flags=%b cnt=0",
                         i, {locked_o, dir_o, mode_o, err_o}, err_cnt_o, e[i]);
            end
        end
    endtask

    task automatic test_saturate();
        logic [2:0] s  [7] = '{3'd0, 3'd1, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4};
        logic [3:0] e  [7] = '{4'b0100, 4'b1100, 4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0101};
        int         cw [7] = '{0, 0, 1, 2, 3, 4, 5};
        int         cs [7] = '{0, 0, 1, 2, 3, 3, 3};
        drive(1'b1, 1'b0, 3'd0);
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 1'b1, s[i]);
            vectors++;
            if ({locked_o, dir_o, mode_o, err_o} !== e[i] || err_cnt_o !== 8'(cw[i])) begin
                miscompares++;
                $display("FAIL saturate_w8[%0d] flags=%b cnt=%0d want flags=%b cnt=%0d",
                         i, {locked_o, dir_o, mode_o, err_o}, err_cnt_o, e[i], cw[i]);
            end
            vectors++;
            if ({s_locked_o, s_dir_o, s_mode_o, s_err_o} !== e[i] || s_err_cnt_o !== 2'(cs[i])) begin
                miscompares++;
                $display("FAIL saturate_w2[%0d] flags=%b cnt=%0d want flags=%b cnt=%0d",
                         i, {s_locked_o, s_dir_o, s_mode_o, s_err_o}, s_err_cnt_o, e[i], cs[i]);
            end
        end
    endtask

    task automatic test_gap_and_midreset();
        logic       r [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic       v [10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [2:0] s [10] = '{3'd0, 3'd1, 3'd2, 3'd5, 3'd5, 3'd5, 3'd3, 3'd5, 3'd7, 3'd0};
        logic [3:0] e [10] = '{4'b0100, 4'b1100, 4'b1100, 4'b1100, 4'b1100,
                               4'b1100, 4'b1100, 4'b0100, 4'b0100, 4'b1100};
        drive(1'b1, 1'b0, 3'd0);
        for (int i = 0; i < 10; i++) begin
            drive(r[i], v[i], s[i]);
            vectors++;
            if ({locked_o, dir_o, mode_o, err_o} !== e[i] || err_cnt_o !== 8'd0) begin
                miscompares++;
                $display("FAIL gap_midreset[%0d] flags=%b cnt=%0d want flags=%b cnt=0",
                         i, {locked_o, dir_o, mode_o, err_o}, err_cnt_o, e[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_wrap();
        test_reversal();
        test_error_recover();
        test_sync_bad();
        test_saturate();
        test_gap_and_midreset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/updown_count_decoder.md
Name: updown_count_decoder

Overview:
Receive-side companion to the 3-bit up/down counter. It watches the counter's output stream and recovers the counting direction and the mode-toggle events. It also checks that every sample is a legal ±1 step, with wrap-around. It sits on the observing end of any counter link, for example a monitor or remote replica, and reports lock status and a saturating error count.

Parameters:
W, 3, count width in bits; modulus 2^W
ERR_CNT_W, 8, width of saturating error counter

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  synchronous, active-high reset
valid_i  input  1  count_i carries a new sample this cycle
count_i  input  W  observed counter value
dir_o  output  1  recovered direction: 1 = up, 0 = down
mode_o  output  1  one-cycle pulse: direction reversal detected
locked_o  output  1  high while in LOCKED state
err_o  output  1  one-cycle pulse: illegal step detected
err_cnt_o  output  ERR_CNT_W  saturating count of illegal steps

Behaviour:
- One clock domain. Reset is synchronous and active-high on rst_i; it has priority over everything.
- All outputs are registered. A sample accepted on edge N is reflected in the outputs right after edge N (latency 1).
- Reset values:
  - state = IDLE
  - prev sample = 0
  - dir_o = 1, matching the counter's reset direction
  - mode_o = 0, err_o = 0, locked_o = 0, err_cnt_o = 0
- valid_i = 0: state, prev, dir_o and err_cnt_o hold; mode_o and err_o are 0. Gaps in valid are transparent, so the next valid sample is compared with the last valid one.
- Step classification on a valid sample, with delta = (count_i - prev) mod 2^W:
  - delta == 1: UP
  - delta == 2^W-1: DOWN
  - anything else, including 0: BAD
  - Wrap is legal: 7→0 is UP and 0→7 is DOWN (W=3).
- Every valid sample updates prev, in every state.
- FSM states: IDLE, SYNC, LOCKED, ERROR.
  - IDLE: on valid → SYNC. No classification.
  - SYNC:
    - UP/DOWN → LOCKED; dir_o set from the step; no mode_o pulse.
    - BAD → stay in SYNC; no err_o, no count. BAD steps before first lock are not errors.
  - LOCKED:
    - Step agrees with dir_o → stay.
    - Step opposes dir_o → stay; dir_o toggles; mode_o pulses for 1 cycle.
    - BAD → ERROR; err_o pulses; err_cnt_o increments.
  - ERROR:
    - UP/DOWN → LOCKED; dir_o set from the step; no mode_o pulse.
    - BAD → stay in ERROR; err_o pulses; err_cnt_o increments.
- err_cnt_o saturates at 2^ERR_CNT_W-1. err_o still pulses when the counter is saturated.
- locked_o = (state == LOCKED).
- mode_o and err_o are mutually exclusive by construction.
- Reset asserted mid-stream: on the next edge all state returns to reset values regardless of valid_i. Sampling resumes from IDLE.

Decomposition:
- Package updown_pkg holds:
  - state enum: IDLE, SYNC, LOCKED, ERROR
  - step enum: STEP_UP, STEP_DOWN, STEP_BAD
  - default width constants
- One natural sub-module: updown_step_classify. It is combinational and maps (count_i, prev, W) to a step code. It can be reused by the counter's own assertions.

Test Plan:
1. Reset, then feed 0,1,2,3 with valid = 1 → after sample 1: locked_o = 1, dir_o = 1. mode_o, err_o and err_cnt_o stay 0 throughout.
2. Feed 6,7,0,1, then 1,0,7,6 (W = 3) → wraps accepted with no err_o. One mode_o pulse on the second "1"→"0" step; dir_o = 0 afterwards.
3. Feed 0,1,2,1,0 → mode_o high exactly one cycle after the sample "1" (4th). dir_o goes 1→0. locked_o stays 1.
4. Feed 2,3,5,6 → err_o pulses at sample 5, err_cnt_o = 1, locked_o = 0. At sample 6: locked_o = 1, dir_o = 1, no mode_o pulse.
5. ERR_CNT_W = 2: lock, then feed five consecutive BAD steps (repeat value 4) → err_o pulses 5 times; err_cnt_o reads 1,2,3,3,3.
6. Lock on 0,1,2, then valid low for 3 cycles, then 3 → no error, state held during gap. Then assert rst_i for one cycle while valid = 1 → next cycle all outputs at reset values. The next sample is treated as the IDLE capture.
